// File: rtl/row_scan_motion_controller_pkg.sv
// Shared types for the RGBY-ROM reader head motion controller.
package rgby_motion_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HOME,
        MOVE_FIRST,
        SCAN,
        TRAVERSE,
        PARK,
        DONE,
        FAULT
    } scanState_t;

    localparam logic UP   = 1'b1;
    localparam logic DOWN = 1'b0;

    function automatic logic isMove(scanState_t s);
        return s inside {HOME, MOVE_FIRST, TRAVERSE, PARK};
    endfunction

endpackage

// File: rtl/row_scan_motion_controller_step.sv
// Move engine: direction setup delay, step pitch/width timing,
// pulse counting and limit-terminated stop.
module step_pulse_generator
    import rgby_motion_pkg::*;
#(
    parameter int STEP_PERIOD_CYCLES = 512,
    parameter int STEP_PULSE_CYCLES  = 4,
    parameter int DIR_SETUP_CYCLES   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        go,
    input  logic [15:0] count,
    input  logic        limit_mode,
    input  logic        lim,
    input  logic        clear,
    output logic        step,
    output logic [15:0] pulses,
    output logic        move_done
);

    localparam logic [15:0] SETUP_LOAD  = 16'(DIR_SETUP_CYCLES - 1);
    localparam logic [15:0] PERIOD_LOAD = 16'(STEP_PERIOD_CYCLES - 1);
    localparam logic [15:0] FALL_AT     = 16'(STEP_PERIOD_CYCLES - STEP_PULSE_CYCLES);

    logic        active;
    logic        limMode;
    logic [15:0] cycleCnt;
    logic [15:0] target;
    logic        stopNow;

    assign stopNow = limMode && lim;

    always_ff @(posedge clk) begin
        move_done <= 1'b0;
        if (reset || clear) begin
            active   <= 1'b0;
            limMode  <= 1'b0;
            step     <= 1'b0;
            pulses   <= '0;
            cycleCnt <= '0;
            target   <= '0;
        end else if (go) begin
            active   <= 1'b1;
            limMode  <= limit_mode;
            step     <= 1'b0;
            pulses   <= '0;
            cycleCnt <= SETUP_LOAD;
            target   <= count;
        end else if (active) begin
            // A pulse always finishes its width; the stop decision is taken as it falls
            if (step && cycleCnt == FALL_AT) begin
                step <= 1'b0;
                if (pulses == target || stopNow) begin
                    active    <= 1'b0;
                    move_done <= 1'b1;
                end
            end
            if (cycleCnt != '0) begin
                cycleCnt <= cycleCnt - 16'd1;
            end else if (stopNow || pulses == target) begin
                active    <= 1'b0;
                move_done <= 1'b1;
            end else begin
                step     <= 1'b1;
                pulses   <= pulses + 16'd1;
                cycleCnt <= PERIOD_LOAD;
            end
        end
    end

endmodule

// File: rtl/row_scan_motion_controller.sv
// Row scan sequencer: homes the reader head, steps across the nit rows
// handing each to the selector, then parks on the limit switch.
module row_scan_motion_controller
    import rgby_motion_pkg::*;
#(
    parameter int NUM_ROWS           = 32,
    parameter int FIRST_ROW_STEPS    = 550,
    parameter int STEPS_BETWEEN_ROWS = 181,
    parameter int STEP_PERIOD_CYCLES = 512,
    parameter int STEP_PULSE_CYCLES  = 4,
    parameter int DIR_SETUP_CYCLES   = 16,
    parameter int HOME_MAX_STEPS     = 20000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic       limitSwitch,
    input  logic       selectorComplete,
    output logic       startSelector,
    output logic       direction,
    output logic       step,
    output logic [7:0] rowIndex,
    output logic       busy,
    output logic       done,
    output logic       fault
);

    localparam logic [7:0]  LAST_ROW    = 8'(NUM_ROWS - 1);
    localparam logic [15:0] HOME_BUDGET = 16'(HOME_MAX_STEPS);

    scanState_t  stateQ, stateD;
    logic        limMeta, limS;
    logic        go, clear, limitMode, moveDone;
    logic [15:0] count, pulses;

    always_ff @(posedge clk) begin
        if (reset) {limMeta, limS} <= 2'b00;
        else       {limMeta, limS} <= {limitSwitch, limMeta};
    end

    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            IDLE, DONE, FAULT:
                if (start) stateD = HOME;
            HOME:
                if (limS && !step) stateD = MOVE_FIRST;
                else if (moveDone && pulses == HOME_BUDGET) stateD = FAULT;
            MOVE_FIRST, TRAVERSE:
                if (moveDone) stateD = SCAN;
            SCAN:
                if (selectorComplete)
                    stateD = (rowIndex == LAST_ROW) ? PARK : TRAVERSE;
            PARK:
                if (limS && !step) stateD = DONE;
                else if (moveDone && pulses == HOME_BUDGET) stateD = FAULT;
            default:
                stateD = IDLE;
        endcase
        if (abort) stateD = IDLE;

        // Re-arm a limit move that stopped short without the switch closing
        go        = isMove(stateD) && (stateD != stateQ || moveDone);
        clear     = abort || (isMove(stateQ) && !isMove(stateD));
        limitMode = (stateD == HOME) || (stateD == PARK);
        count     = HOME_BUDGET;
        if (stateD == MOVE_FIRST) count = 16'(FIRST_ROW_STEPS);
        if (stateD == TRAVERSE)   count = 16'(STEPS_BETWEEN_ROWS);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ        <= IDLE;
            direction     <= UP;
            startSelector <= 1'b0;
            rowIndex      <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            fault         <= 1'b0;
        end else begin
            stateQ        <= stateD;
            startSelector <= (stateD == SCAN) && (stateQ != SCAN);
            if (stateD == HOME || stateD == PARK)
                direction <= UP;
            else if (stateD == MOVE_FIRST || stateD == TRAVERSE)
                direction <= DOWN;
            if (abort || (stateD == HOME && stateQ != HOME))
                rowIndex <= '0;
            else if (stateQ == SCAN && stateD == TRAVERSE && rowIndex != LAST_ROW)
                rowIndex <= rowIndex + 8'd1;
            busy  <= !(stateD inside {IDLE, DONE, FAULT});
            done  <= (stateD == DONE);
            fault <= (stateD == FAULT);
        end
    end

    step_pulse_generator #(
        .STEP_PERIOD_CYCLES(STEP_PERIOD_CYCLES),
        .STEP_PULSE_CYCLES (STEP_PULSE_CYCLES),
        .DIR_SETUP_CYCLES  (DIR_SETUP_CYCLES)
    ) uEngine (
        .clk       (clk),
        .reset     (reset),
        .go        (go),
        .count     (count),
        .limit_mode(limitMode),
        .lim       (limS),
        .clear     (clear),
        .step      (step),
        .pulses    (pulses),
        .move_done (moveDone)
    );

endmodule

// File: tb/tb_row_scan_motion_controller.sv
// Bench for row_scan_motion_controller: head position model drives the
// limit switch, a selector model answers each startSelector.
module tb_row_scan_motion_controller;

    localparam int NR  = 3;
    localparam int FRS = 5;
    localparam int SBR = 2;
    localparam int SPC = 8;
    localparam int SPW = 2;
    localparam int DSC = 4;
    localparam int HMS = 10;
    localparam int EXP_DOWN = FRS + (NR - 1) * SBR;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       limitSwitch = 1'b0;
    logic       selectorComplete = 1'b0;
    logic       startSelector, direction, step, busy, done, fault;
    logic [7:0] rowIndex;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int upCnt = 0;
    int downCnt = 0;
    int lastFall = 0;
    logic stepPrev = 1'b0;
    logic dirPrev = 1'b1;
    int riseQ[$];
    int fallQ[$];
    int dirChgQ[$];
    int rowQ[$];
    int lagQ[$];

    row_scan_motion_controller #(
        .NUM_ROWS(NR), .FIRST_ROW_STEPS(FRS), .STEPS_BETWEEN_ROWS(SBR),
        .STEP_PERIOD_CYCLES(SPC), .STEP_PULSE_CYCLES(SPW),
        .DIR_SETUP_CYCLES(DSC), .HOME_MAX_STEPS(HMS)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .limitSwitch(limitSwitch), .selectorComplete(selectorComplete),
        .startSelector(startSelector), .direction(direction), .step(step),
        .rowIndex(rowIndex), .busy(busy), .done(done), .fault(fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        stepPrev <= step;
        dirPrev  <= direction;
        if (step === 1'b1 && stepPrev === 1'b0) begin
            riseQ.push_back(cyc);
            if (direction) upCnt <= upCnt + 1;
            else           downCnt <= downCnt + 1;
        end
        if (step === 1'b0 && stepPrev === 1'b1) begin
            fallQ.push_back(cyc);
            lastFall <= cyc;
        end
        if (direction !== dirPrev) dirChgQ.push_back(cyc);
        if (startSelector === 1'b1) begin
            rowQ.push_back(int'(rowIndex));
            lagQ.push_back(cyc - lastFall);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Head starts closeAfter UP steps from home; switch is closed at position <= 0.
    task automatic runScan(input int closeAfter, input bit randDelay,
                           input int cutRow, input bit cutReset);
        int up0, dn0, upMid, sel0, selSeen, due, n, d;
        bit midSeen, cut;
        limitSwitch = (closeAfter <= 0);
        repeat (4) tick();
        up0 = upCnt; dn0 = downCnt; upMid = up0;
        sel0 = rowQ.size(); selSeen = sel0;
        due = -1; n = 0; midSeen = 0; cut = 0;
        start = 1'b1; tick(); start = 1'b0;
        chk("busyAfterStart", busy, 1);
        chk("homeDirUp", direction, 1);
        if (closeAfter == 0) begin
            tick();
            chk("homeSkipToMoveFirst", direction, 0);
        end
        while (!done && !fault && !cut && n < 3000) begin
            tick();
            n++;
            limitSwitch = (closeAfter - (upCnt - up0) + (downCnt - dn0)) <= 0;
            if (!midSeen && direction == 1'b0) begin
                midSeen = 1;
                upMid = upCnt;
            end
            selectorComplete = 1'b0;
            if (rowQ.size() != selSeen) begin
                selSeen = rowQ.size();
                d = randDelay ? int'($urandom_range(7, 2)) : 5;
                due = n + d - 2;
            end
            if (n == due) selectorComplete = 1'b1;
            if (cutRow >= 0 && step && direction == 1'b0 && int'(rowIndex) == cutRow) begin
                cut = 1;
                selectorComplete = 1'b0;
                if (cutReset) begin
                    reset = 1'b1; tick();
                    chk("rstStep", step, 0);
                    chk("rstDir", direction, 1);
                    chk("rstSel", startSelector, 0);
                    chk("rstRow", rowIndex, 0);
                    chk("rstBusy", busy, 0);
                    chk("rstDone", done, 0);
                    chk("rstFault", fault, 0);
                    reset = 1'b0;
                end else begin
                    abort = 1'b1; start = 1'b1; tick();
                    chk("abortStep", step, 0);
                    chk("abortRow", rowIndex, 0);
                    chk("abortBusy", busy, 0);
                    chk("abortSel", startSelector, 0);
                    abort = 1'b0; start = 1'b0; tick();
                    chk("abortStartIgnored", busy, 0);
                    chk("abortStepLow", step, 0);
                end
            end
        end
        selectorComplete = 1'b0;
        if (!cut) begin
            chk("runDone", done, 1);
            chk("runNoFault", fault, 0);
            chk("runBusyLow", busy, 0);
            chk("homeUpSteps", upMid - up0, closeAfter);
            chk("downSteps", downCnt - dn0, EXP_DOWN);
            chk("parkUpSteps", upCnt - upMid, EXP_DOWN);
            chk("selPulses", rowQ.size() - sel0, NR);
            for (int i = 0; i < NR; i++) begin
                chk("selRowIndex", rowQ[sel0 + i], i);
                chk("selAfterFall", lagQ[sel0 + i], 1);
            end
        end
    endtask

    initial begin
        int r0, d0, u0, n, s0;

        reset = 1'b1;
        repeat (3) tick();
        chk("resetStep", step, 0);
        chk("resetDir", direction, 1);
        chk("resetSel", startSelector, 0);
        chk("resetRow", rowIndex, 0);
        chk("resetBusy", busy, 0);
        chk("resetDone", done, 0);
        chk("resetFault", fault, 0);
        reset = 1'b0;
        tick();
        chk("idleBusy", busy, 0);

        // Full run: switch closes after 3 UP steps, selector answers in 5 clocks
        r0 = riseQ.size();
        d0 = dirChgQ.size();
        runScan(3, 1'b0, -1, 1'b0);
        chk("setupToFirstStep", riseQ[r0 + 3] - dirChgQ[d0], DSC);
        for (int i = 0; i < 8; i++)
            chk("pulseWidth", fallQ[r0 + i] - riseQ[r0 + i], SPW);
        for (int i = 1; i < 8; i++)
            if (i != 3) chk("pulsePitch", riseQ[r0 + i] - riseQ[r0 + i - 1], SPC);

        // Switch already closed at start
        runScan(0, 1'b0, -1, 1'b0);

        // Switch never closes: budget exhausted
        limitSwitch = 1'b0;
        repeat (4) tick();
        u0 = upCnt;
        start = 1'b1; tick(); start = 1'b0;
        n = 0;
        while (!fault && n < 500) begin
            tick();
            n++;
        end
        repeat (3) tick();
        chk("faultRaised", fault, 1);
        chk("faultUpSteps", upCnt - u0, HMS);
        chk("faultBusy", busy, 0);
        chk("faultDone", done, 0);
        start = 1'b1; tick(); start = 1'b0;
        chk("faultRestartBusy", busy, 1);
        chk("faultRestartClear", fault, 0);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("abortFromHome", busy, 0);

        // Abort mid-pulse during the first TRAVERSE
        runScan(2, 1'b0, 1, 1'b0);

        repeat (2) runScan(int'($urandom_range(5, 1)), 1'b1, -1, 1'b0);

        // Reset mid-pulse during MOVE_FIRST, then a stray selectorComplete
        runScan(3, 1'b1, 0, 1'b1);
        tick();
        s0 = rowQ.size();
        selectorComplete = 1'b1; tick(); selectorComplete = 1'b0;
        repeat (3) tick();
        chk("idleSelBusy", busy, 0);
        chk("idleSelPulses", rowQ.size() - s0, 0);
        chk("idleSelRow", rowIndex, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
